// File: rtl/time_of_day_counter_if.sv
// Signal bundle between the alarm-clock control plane and the time-of-day counter.
// The master side drives tick/load/alarm controls; the slave side returns time and status.
interface time_of_day_counter_if;
    logic       tick_in;
    logic       load;
    logic [7:0] load_hh;
    logic [7:0] load_mm;
    logic [7:0] load_ss;
    logic       alarm_en;
    logic [7:0] alarm_hh;
    logic [7:0] alarm_mm;
    logic       alarm_stop;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       sec_tick;
    logic       load_err;
    logic       alarm_ring;

    modport master (
        output tick_in, load, load_hh, load_mm, load_ss,
        output alarm_en, alarm_hh, alarm_mm, alarm_stop,
        input  hh, mm, ss, sec_tick, load_err, alarm_ring
    );

    modport slave (
        input  tick_in, load, load_hh, load_mm, load_ss,
        input  alarm_en, alarm_hh, alarm_mm, alarm_stop,
        output hh, mm, ss, sec_tick, load_err, alarm_ring
    );
endinterface

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter with validated load and a timed alarm ring.
//   state    | meaning
//   ST_IDLE  | no alarm active, waiting for a tick-driven compare hit
//   ST_RING  | alarm_ring high, counting seconds until timeout/stop/disarm/load
module time_of_day_counter #(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned RING_SECS     = 60
) (
    input  logic                   clk,
    input  logic                   rst,
    time_of_day_counter_if.slave   bus
);

    typedef enum logic {ST_IDLE, ST_RING} state_t;

    localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);
    localparam logic [7:0] RING_LAST  = 8'(RING_SECS);

    state_t     state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] hh_q, hh_d;
    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;
    logic       sec_tick_q, sec_tick_d;
    logic       load_err_q, load_err_d;
    logic       ring_q, ring_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;

    logic       load_ok;
    logic       load_take;
    logic       inc_evt;
    logic       hit;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Advance a two-digit BCD field; wraps to 00 after 'last'.
    function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        presc_d    = presc_q;
        hh_d       = hh_q;
        mm_d       = mm_q;
        ss_d       = ss_q;
        sec_tick_d = 1'b0;
        load_err_d = 1'b0;
        inc_evt    = 1'b0;
        hit        = 1'b0;
        load_ok    = bcd_ok(bus.load_hh, 8'h23) && bcd_ok(bus.load_mm, 8'h59) &&
                     bcd_ok(bus.load_ss, 8'h59);
        load_take  = bus.load && load_ok;

        // A load strobe always consumes the cycle, so a coincident tick is dropped.
        if (bus.load) begin
            if (load_ok) begin
                hh_d    = bus.load_hh;
                mm_d    = bus.load_mm;
                ss_d    = bus.load_ss;
                presc_d = 8'd0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.tick_in) begin
            if (presc_q >= PRESC_LAST) begin
                presc_d    = 8'd0;
                inc_evt    = 1'b1;
                sec_tick_d = 1'b1;
                ss_d       = bcd_next(ss_q, 8'h59);
                if (ss_q == 8'h59) begin
                    mm_d = bcd_next(mm_q, 8'h59);
                    if (mm_q == 8'h59)
                        hh_d = bcd_next(hh_q, 8'h23);
                end
                hit = bus.alarm_en && (ss_d == 8'h00) &&
                      (mm_d == bus.alarm_mm) && (hh_d == bus.alarm_hh);
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        case (state_q)
            ST_IDLE: begin
                ring_d = 1'b0;
                if (hit) begin
                    state_d    = ST_RING;
                    ring_d     = 1'b1;
                    ring_cnt_d = 8'd0;
                end
            end
            ST_RING: begin
                ring_d = 1'b1;
                if (inc_evt)
                    ring_cnt_d = ring_cnt_q + 8'd1;
                // Re-hits while ringing are ignored; only these conditions end the ring.
                if ((ring_cnt_q >= RING_LAST) || bus.alarm_stop || !bus.alarm_en || load_take) begin
                    state_d    = ST_IDLE;
                    ring_d     = 1'b0;
                    ring_cnt_d = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= 8'd0;
            hh_q       <= 8'h00;
            mm_q       <= 8'h00;
            ss_q       <= 8'h00;
            sec_tick_q <= 1'b0;
            load_err_q <= 1'b0;
            ring_q     <= 1'b0;
            ring_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            sec_tick_q <= sec_tick_d;
            load_err_q <= load_err_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    assign bus.hh         = hh_q;
    assign bus.mm         = mm_q;
    assign bus.ss         = ss_q;
    assign bus.sec_tick   = sec_tick_q;
    assign bus.load_err   = load_err_q;
    assign bus.alarm_ring = ring_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: one instance at 1 tick/s with a 3 s ring,
// one at 2 ticks/s with a 62 s ring for prescaler, load and re-hit scenarios.
module tb_time_of_day_counter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    time_of_day_counter_if bus_p1();
    time_of_day_counter_if bus_p2();

    time_of_day_counter #(.TICKS_PER_SEC(1), .RING_SECS(3)) dut_p1 (
        .clk (clk),
        .rst (rst),
        .bus (bus_p1)
    );

    time_of_day_counter #(.TICKS_PER_SEC(2), .RING_SECS(62)) dut_p2 (
        .clk (clk),
        .rst (rst),
        .bus (bus_p2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        bus_p1.tick_in = 1'b1;
        cyc();
        bus_p1.tick_in = 1'b0;
    endtask

    task automatic tick2();
        bus_p2.tick_in = 1'b1;
        cyc();
        bus_p2.tick_in = 1'b0;
    endtask

    task automatic load1(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus_p1.load = 1'b1; bus_p1.load_hh = h; bus_p1.load_mm = m; bus_p1.load_ss = s;
        cyc();
        bus_p1.load = 1'b0;
    endtask

    task automatic load2(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bus_p2.load = 1'b1; bus_p2.load_hh = h; bus_p2.load_mm = m; bus_p2.load_ss = s;
        cyc();
        bus_p2.load = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] o1, o2;
        rst = 1'b0;
        cyc();
        cyc();
        o1 = {bus_p1.hh, bus_p1.mm, bus_p1.ss, bus_p1.sec_tick, bus_p1.load_err, bus_p1.alarm_ring};
        o2 = {bus_p2.hh, bus_p2.mm, bus_p2.ss, bus_p2.sec_tick, bus_p2.load_err, bus_p2.alarm_ring};
        n_tests++;
        if (o1 !== 27'd0) begin n_fail++; $display("FAIL reset_p1: got %h expected 0", o1); end
        n_tests++;
        if (o2 !== 27'd0) begin n_fail++; $display("FAIL reset_p2: got %h expected 0", o2); end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_prescale();
        int pulses;
        logic exp_st;
        pulses = 0;
        load2(8'h00, 8'h00, 8'h00);
        for (int i = 1; i <= 6; i++) begin
            tick2();
            exp_st = (i % 2 == 0);
            n_tests++;
            if (bus_p2.sec_tick !== exp_st) begin
                n_fail++;
                $display("FAIL prescale_sec_tick[%0d]: got %b expected %b", i, bus_p2.sec_tick, exp_st);
            end
            if (bus_p2.sec_tick === 1'b1) pulses++;
            cyc();
            if (bus_p2.sec_tick === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 3) begin n_fail++; $display("FAIL prescale_pulses: got %0d expected 3", pulses); end
        n_tests++;
        if ({bus_p2.hh, bus_p2.mm, bus_p2.ss} !== 24'h000003) begin
            n_fail++; $display("FAIL prescale_time: got %h expected 000003", {bus_p2.hh, bus_p2.mm, bus_p2.ss});
        end
    endtask

    task automatic test_rollover();
        load1(8'h23, 8'h59, 8'h59);
        n_tests++;
        if ({bus_p1.hh, bus_p1.mm, bus_p1.ss} !== 24'h235959) begin
            n_fail++; $display("FAIL rollover_load: got %h expected 235959", {bus_p1.hh, bus_p1.mm, bus_p1.ss});
        end
        tick1();
        n_tests++;
        if ({bus_p1.hh, bus_p1.mm, bus_p1.ss, bus_p1.sec_tick} !== 25'h0000001) begin
            n_fail++; $display("FAIL rollover_wrap: got %h expected 0000001", {bus_p1.hh, bus_p1.mm, bus_p1.ss, bus_p1.sec_tick});
        end
        cyc();
        n_tests++;
        if (bus_p1.sec_tick !== 1'b0) begin n_fail++; $display("FAIL rollover_pulse_width: got %b expected 0", bus_p1.sec_tick); end
    endtask

    task automatic test_load_err();
        logic [23:0] bad [4];
        logic [23:0] t;
        bad[0] = 24'h240000; bad[1] = 24'h005A00; bad[2] = 24'h000060; bad[3] = 24'h1A0000;
        for (int i = 0; i < 4; i++) begin
            load2(bad[i][23:16], bad[i][15:8], bad[i][7:0]);
            t = {bus_p2.hh, bus_p2.mm, bus_p2.ss};
            n_tests++;
            if ({bus_p2.load_err, bus_p2.sec_tick, t} !== {2'b10, 24'h000003}) begin
                n_fail++; $display("FAIL load_err[%0d]: got err=%b st=%b t=%h expected err=1 st=0 t=000003",
                                   i, bus_p2.load_err, bus_p2.sec_tick, t);
            end
            cyc();
            n_tests++;
            if (bus_p2.load_err !== 1'b0) begin n_fail++; $display("FAIL load_err_width[%0d]: got 1 expected 0", i); end
        end
        tick2();
        // valid load with coincident tick: load wins and the prescaler restarts
        bus_p2.tick_in = 1'b1;
        bus_p2.load = 1'b1; bus_p2.load_hh = 8'h12; bus_p2.load_mm = 8'h34; bus_p2.load_ss = 8'h56;
        cyc();
        bus_p2.tick_in = 1'b0; bus_p2.load = 1'b0;
        n_tests++;
        if ({bus_p2.hh, bus_p2.mm, bus_p2.ss, bus_p2.sec_tick, bus_p2.load_err} !== {24'h123456, 2'b00}) begin
            n_fail++; $display("FAIL load_tick: got %h st=%b err=%b expected 123456 st=0 err=0",
                               {bus_p2.hh, bus_p2.mm, bus_p2.ss}, bus_p2.sec_tick, bus_p2.load_err);
        end
        tick2();
        n_tests++;
        if ({bus_p2.ss, bus_p2.sec_tick} !== {8'h56, 1'b0}) begin
            n_fail++; $display("FAIL load_presc_clr1: got ss=%h st=%b expected ss=56 st=0", bus_p2.ss, bus_p2.sec_tick);
        end
        tick2();
        n_tests++;
        if ({bus_p2.ss, bus_p2.sec_tick} !== {8'h57, 1'b1}) begin
            n_fail++; $display("FAIL load_presc_clr2: got ss=%h st=%b expected ss=57 st=1", bus_p2.ss, bus_p2.sec_tick);
        end
        // invalid load with coincident tick: tick still discarded
        tick2();
        bus_p2.tick_in = 1'b1;
        bus_p2.load = 1'b1; bus_p2.load_hh = 8'h24; bus_p2.load_mm = 8'h00; bus_p2.load_ss = 8'h00;
        cyc();
        bus_p2.tick_in = 1'b0; bus_p2.load = 1'b0;
        n_tests++;
        if ({bus_p2.load_err, bus_p2.sec_tick, bus_p2.hh, bus_p2.mm, bus_p2.ss} !== {2'b10, 24'h123457}) begin
            n_fail++; $display("FAIL bad_load_tick: got err=%b st=%b t=%h expected err=1 st=0 t=123457",
                               bus_p2.load_err, bus_p2.sec_tick, {bus_p2.hh, bus_p2.mm, bus_p2.ss});
        end
        tick2();
        n_tests++;
        if ({bus_p2.ss, bus_p2.sec_tick} !== {8'h58, 1'b1}) begin
            n_fail++; $display("FAIL bad_load_tick_drop: got ss=%h st=%b expected ss=58 st=1", bus_p2.ss, bus_p2.sec_tick);
        end
    endtask

    task automatic test_alarm();
        bus_p1.alarm_en = 1'b1; bus_p1.alarm_hh = 8'h07; bus_p1.alarm_mm = 8'h30;
        load1(8'h07, 8'h29, 8'h59);
        n_tests++;
        if (bus_p1.alarm_ring !== 1'b0) begin n_fail++; $display("FAIL alarm_pre: got 1 expected 0"); end
        tick1();
        n_tests++;
        if ({bus_p1.hh, bus_p1.mm, bus_p1.ss, bus_p1.alarm_ring} !== {24'h073000, 1'b1}) begin
            n_fail++; $display("FAIL alarm_hit: got t=%h ring=%b expected t=073000 ring=1",
                               {bus_p1.hh, bus_p1.mm, bus_p1.ss}, bus_p1.alarm_ring);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            tick1();
            n_tests++;
            if ({bus_p1.sec_tick, bus_p1.alarm_ring} !== 2'b11) begin
                n_fail++; $display("FAIL alarm_hold[%0d]: got st=%b ring=%b expected st=1 ring=1",
                                   k, bus_p1.sec_tick, bus_p1.alarm_ring);
            end
        end
        cyc();
        n_tests++;
        if (bus_p1.alarm_ring !== 1'b0) begin n_fail++; $display("FAIL alarm_timeout: got 1 expected 0"); end
    endtask

    task automatic test_stop();
        load1(8'h07, 8'h29, 8'h59);
        tick1();
        n_tests++;
        if (bus_p1.alarm_ring !== 1'b1) begin n_fail++; $display("FAIL stop_ring_on: got 0 expected 1"); end
        bus_p1.alarm_stop = 1'b1;
        cyc();
        bus_p1.alarm_stop = 1'b0;
        n_tests++;
        if (bus_p1.alarm_ring !== 1'b0) begin n_fail++; $display("FAIL stop_ring_off: got 1 expected 0"); end
        load1(8'h07, 8'h30, 8'h00);
        cyc();
        n_tests++;
        if ({bus_p1.hh, bus_p1.mm, bus_p1.ss, bus_p1.alarm_ring} !== {24'h073000, 1'b0}) begin
            n_fail++; $display("FAIL load_match_no_ring: got t=%h ring=%b expected t=073000 ring=0",
                               {bus_p1.hh, bus_p1.mm, bus_p1.ss}, bus_p1.alarm_ring);
        end
        load1(8'h07, 8'h29, 8'h59);
        tick1();
        bus_p1.alarm_en = 1'b0;
        cyc();
        n_tests++;
        if (bus_p1.alarm_ring !== 1'b0) begin n_fail++; $display("FAIL disarm_ring_off: got 1 expected 0"); end
        bus_p1.alarm_en = 1'b1;
        load1(8'h07, 8'h29, 8'h59);
        tick1();
        load1(8'h01, 8'h00, 8'h00);
        n_tests++;
        if ({bus_p1.hh, bus_p1.mm, bus_p1.ss, bus_p1.alarm_ring} !== {24'h010000, 1'b0}) begin
            n_fail++; $display("FAIL load_ring_off: got t=%h ring=%b expected t=010000 ring=0",
                               {bus_p1.hh, bus_p1.mm, bus_p1.ss}, bus_p1.alarm_ring);
        end
    endtask

    task automatic test_rehit();
        int drops;
        drops = 0;
        bus_p2.alarm_en = 1'b1; bus_p2.alarm_hh = 8'h07; bus_p2.alarm_mm = 8'h30;
        load2(8'h07, 8'h29, 8'h59);
        tick2();
        tick2();
        n_tests++;
        if ({bus_p2.hh, bus_p2.mm, bus_p2.ss, bus_p2.alarm_ring} !== {24'h073000, 1'b1}) begin
            n_fail++; $display("FAIL rehit_start: got t=%h ring=%b expected t=073000 ring=1",
                               {bus_p2.hh, bus_p2.mm, bus_p2.ss}, bus_p2.alarm_ring);
        end
        bus_p2.alarm_mm = 8'h31;
        for (int s = 1; s <= 62; s++) begin
            tick2();
            tick2();
            if (bus_p2.alarm_ring !== 1'b1) drops++;
        end
        n_tests++;
        if (drops != 0) begin n_fail++; $display("FAIL rehit_continuous: got %0d drops expected 0", drops); end
        n_tests++;
        if ({bus_p2.hh, bus_p2.mm, bus_p2.ss} !== 24'h073102) begin
            n_fail++; $display("FAIL rehit_time: got %h expected 073102", {bus_p2.hh, bus_p2.mm, bus_p2.ss});
        end
        cyc();
        n_tests++;
        if (bus_p2.alarm_ring !== 1'b0) begin n_fail++; $display("FAIL rehit_single_timeout: got 1 expected 0"); end
    endtask

    task automatic test_reset_mid();
        logic [26:0] o1, o2;
        load1(8'h07, 8'h29, 8'h59);
        tick1();
        tick2();
        n_tests++;
        if (bus_p1.alarm_ring !== 1'b1) begin n_fail++; $display("FAIL midrst_ring_on: got 0 expected 1"); end
        rst = 1'b0;
        bus_p1.tick_in = 1'b1;
        bus_p2.tick_in = 1'b1;
        cyc();
        o1 = {bus_p1.hh, bus_p1.mm, bus_p1.ss, bus_p1.sec_tick, bus_p1.load_err, bus_p1.alarm_ring};
        o2 = {bus_p2.hh, bus_p2.mm, bus_p2.ss, bus_p2.sec_tick, bus_p2.load_err, bus_p2.alarm_ring};
        n_tests++;
        if (o1 !== 27'd0) begin n_fail++; $display("FAIL midrst_p1: got %h expected 0", o1); end
        n_tests++;
        if (o2 !== 27'd0) begin n_fail++; $display("FAIL midrst_p2: got %h expected 0", o2); end
        rst = 1'b1;
        bus_p1.tick_in = 1'b0;
        bus_p2.tick_in = 1'b0;
        cyc();
        tick1();
        n_tests++;
        if ({bus_p1.hh, bus_p1.mm, bus_p1.ss, bus_p1.sec_tick, bus_p1.alarm_ring} !== {24'h000001, 2'b10}) begin
            n_fail++; $display("FAIL midrst_restart_p1: got t=%h st=%b ring=%b expected t=000001 st=1 ring=0",
                               {bus_p1.hh, bus_p1.mm, bus_p1.ss}, bus_p1.sec_tick, bus_p1.alarm_ring);
        end
        tick2();
        n_tests++;
        if ({bus_p2.ss, bus_p2.sec_tick} !== {8'h00, 1'b0}) begin
            n_fail++; $display("FAIL midrst_presc_clr: got ss=%h st=%b expected ss=00 st=0", bus_p2.ss, bus_p2.sec_tick);
        end
        tick2();
        n_tests++;
        if ({bus_p2.ss, bus_p2.sec_tick} !== {8'h01, 1'b1}) begin
            n_fail++; $display("FAIL midrst_restart_p2: got ss=%h st=%b expected ss=01 st=1", bus_p2.ss, bus_p2.sec_tick);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        bus_p1.tick_in = 1'b0; bus_p1.load = 1'b0;
        bus_p1.load_hh = 8'h00; bus_p1.load_mm = 8'h00; bus_p1.load_ss = 8'h00;
        bus_p1.alarm_en = 1'b0; bus_p1.alarm_hh = 8'h00; bus_p1.alarm_mm = 8'h00; bus_p1.alarm_stop = 1'b0;
        bus_p2.tick_in = 1'b0; bus_p2.load = 1'b0;
        bus_p2.load_hh = 8'h00; bus_p2.load_mm = 8'h00; bus_p2.load_ss = 8'h00;
        bus_p2.alarm_en = 1'b0; bus_p2.alarm_hh = 8'h00; bus_p2.alarm_mm = 8'h00; bus_p2.alarm_stop = 1'b0;

        test_reset();
        test_prescale();
        test_rollover();
        test_load_err();
        test_alarm();
        test_stop();
        test_rehit();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
